// File: rtl/piso_pkg.sv
// Shared types and constants for the piso_tx parallel-in serial-out transmitter.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_e;

  // Appended bit makes the total count of ones in the frame even.
  localparam logic PARITY_EVEN = 1'b0;

  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: one WIDTH-bit word per handshake, one bit per clock.
// Define PISO_PARITY_EN to append an even-parity bit as the final frame cycle.
module piso_tx
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] sh_q;
  logic [CW-1:0]    cnt_q;
  logic             ser_out_q;
  logic             ser_valid_q;
  logic             ser_last_q;
`ifdef PISO_PARITY_EN
  logic             par_q;
`endif

  logic             last_bit_c;
  logic             accept_c;
  logic             first_bit_c;
  logic             next_bit_c;
  logic [WIDTH-1:0] sh_shift_c;

  // The final frame cycle is where the next word may be taken without a gap.
`ifdef PISO_PARITY_EN
  assign last_bit_c = (state_q == PAR);
`else
  assign last_bit_c = (state_q == SHIFT) && (cnt_q == CW'(WIDTH - 1));
`endif

  assign in_ready    = (state_q == IDLE) || last_bit_c;
  assign accept_c    = in_valid && in_ready;
  assign first_bit_c = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
  assign next_bit_c  = MSB_FIRST ? sh_q[WIDTH-2] : sh_q[1];
  assign sh_shift_c  = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else if (accept_c) begin
      state_q     <= SHIFT;
      sh_q        <= data_in;
      cnt_q       <= '0;
      ser_out_q   <= first_bit_c;
      ser_valid_q <= 1'b1;
      ser_last_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q       <= (^data_in) ^ PARITY_EVEN;
`endif
    end else begin
      case (state_q)
        SHIFT: begin
          if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef PISO_PARITY_EN
            state_q    <= PAR;
            ser_out_q  <= par_q;
            ser_last_q <= 1'b1;
`else
            state_q     <= IDLE;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
`endif
          end else begin
            cnt_q     <= cnt_q + CW'(1);
            sh_q      <= sh_shift_c;
            ser_out_q <= next_bit_c;
`ifdef PISO_PARITY_EN
            ser_last_q <= 1'b0;
`else
            ser_last_q <= (cnt_q == CW'(WIDTH - 2));
`endif
          end
        end
        PAR: begin
          state_q     <= IDLE;
          ser_out_q   <= 1'b0;
          ser_valid_q <= 1'b0;
          ser_last_q  <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          ser_out_q   <= 1'b0;
          ser_valid_q <= 1'b0;
          ser_last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign ser_last  = ser_last_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: one MSB-first and one LSB-first instance, WIDTH=4.
module tb_piso_tx;

  localparam bit PAR_EN =
`ifdef PISO_PARITY_EN
    1'b1;
`else
    1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] d_m, d_l;
  logic       v_m, v_l;
  logic       rdy_m, so_m, sv_m, sl_m, bz_m;
  logic       rdy_l, so_l, sv_l, sl_l, bz_l;
  int         n_chk;
  int         n_fail;

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .data_in(d_m), .in_valid(v_m), .in_ready(rdy_m),
    .ser_out(so_m), .ser_valid(sv_m), .ser_last(sl_m), .busy(bz_m)
  );

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .data_in(d_l), .in_valid(v_l), .in_ready(rdy_l),
    .ser_out(so_l), .ser_valid(sv_l), .ser_last(sl_l), .busy(bz_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic [3:0] d);
    if (sel) begin
      v_l = v;
      d_l = d;
    end else begin
      v_m = v;
      d_m = d;
    end
  endtask

  task automatic set_valid(input bit sel, input logic v);
    if (sel) v_l = v;
    else     v_m = v;
  endtask

  task automatic chk_out(input bit sel, input string tag, input logic so, input logic sv,
                         input logic sl, input logic rdy, input logic bz);
    chk({tag, ".ser_out"},   32'(sel ? so_l  : so_m),  32'(so));
    chk({tag, ".ser_valid"}, 32'(sel ? sv_l  : sv_m),  32'(sv));
    chk({tag, ".ser_last"},  32'(sel ? sl_l  : sl_m),  32'(sl));
    chk({tag, ".in_ready"},  32'(sel ? rdy_l : rdy_m), 32'(rdy));
    chk({tag, ".busy"},      32'(sel ? bz_l  : bz_m),  32'(bz));
  endtask

  task automatic idle_chk(input bit sel, input string tag);
    @(negedge clk);
    chk_out(sel, tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // exp holds the data bits in wire order (exp[3] first); word must already be presented.
  task automatic frame(input bit sel, input string tag, input logic [3:0] exp,
                       input logic exp_par, input bit glitch, input bit nxt,
                       input logic [3:0] nxt_word);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) set_valid(sel, 1'b0);
      chk_out(sel, $sformatf("%s.b%0d", tag, i), exp[3-i], 1'b1,
              (i == 3) && !PAR_EN, (i == 3) && !PAR_EN, 1'b1);
      if (glitch && i == 1) drive(sel, 1'b1, 4'hF);
      if (glitch && i == 2) set_valid(sel, 1'b0);
      if (nxt && i == 3 && !PAR_EN) drive(sel, 1'b1, nxt_word);
    end
`ifdef PISO_PARITY_EN
    @(negedge clk);
    chk_out(sel, {tag, ".par"}, exp_par, 1'b1, 1'b1, 1'b1, 1'b1);
    if (nxt) drive(sel, 1'b1, nxt_word);
`else
    if (exp_par !== exp_par) n_fail++;
`endif
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    drive(1'b0, 1'b0, 4'h0);
    drive(1'b1, 1'b0, 4'h0);
    repeat (2) @(negedge clk);
    chk_out(1'b0, "in_rst_m", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_out(1'b1, "in_rst_l", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    idle_chk(1'b0, "idle_m");
    idle_chk(1'b1, "idle_l");

    // Single MSB-first frame.
    drive(1'b0, 1'b1, 4'b1011);
    frame(1'b0, "w1011", 4'b1011, 1'b1, 1'b0, 1'b0, 4'h0);
    idle_chk(1'b0, "w1011.end");

    // Back-to-back: 4'h5 presented on the final cycle of 4'hA.
    drive(1'b0, 1'b1, 4'hA);
    frame(1'b0, "wA", 4'b1010, 1'b0, 1'b0, 1'b1, 4'h5);
    frame(1'b0, "w5", 4'b0101, 1'b0, 1'b0, 1'b0, 4'h0);
    idle_chk(1'b0, "w5.end");

    // LSB-first with an ignored mid-frame in_valid carrying 4'hF.
    drive(1'b1, 1'b1, 4'b0001);
    frame(1'b1, "l0001", 4'b1000, 1'b1, 1'b1, 1'b0, 4'h0);
    idle_chk(1'b1, "l0001.end");
    idle_chk(1'b1, "l0001.noextra");

    // Asynchronous reset during the second bit of 4'hC.
    drive(1'b0, 1'b1, 4'hC);
    @(negedge clk);
    set_valid(1'b0, 1'b0);
    chk_out(1'b0, "wC.b0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk_out(1'b0, "wC.b1", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    chk_out(1'b0, "wC.rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    idle_chk(1'b0, "wC.after");
    drive(1'b0, 1'b1, 4'h3);
    frame(1'b0, "w3", 4'b0011, 1'b0, 1'b0, 1'b0, 4'h0);
    idle_chk(1'b0, "w3.end");

    // Parity-sensitive words: odd and even popcount.
    drive(1'b0, 1'b1, 4'b0111);
    frame(1'b0, "w0111", 4'b0111, 1'b1, 1'b0, 1'b0, 4'h0);
    idle_chk(1'b0, "w0111.end");
    drive(1'b0, 1'b1, 4'b0110);
    frame(1'b0, "w0110", 4'b0110, 1'b0, 1'b0, 1'b0, 4'h0);
    idle_chk(1'b0, "w0110.end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
Parallel-in serial-out transmitter; the serializing counterpart to the team's parallel word registers.
- Accepts one WIDTH-bit word per valid/ready handshake and shifts it out one bit per clock on a serial data/valid/last stream.
- Sits between a parallel producer (register bank or datapath) and a 1-bit link or serial-to-parallel receiver.
- Supports back-to-back words with no idle gap.

Parameters:
- WIDTH, 4: data word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 transmitted first; 0 = bit 0 first.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_in  input  WIDTH  parallel word to transmit.
- in_valid  input  1  data_in is valid.
- in_ready  output  1  block will accept a word this cycle.
- ser_out  output  1  serial data bit.
- ser_valid  output  1  ser_out carries a frame bit.
- ser_last  output  1  marks the final bit of the frame.
- busy  output  1  a frame is in flight (state != IDLE).

Behaviour:
- Interface: clk, single clock; rst, asynchronous active-high reset. Everything below is synchronous to clk except reset assertion.
- States:
  - IDLE: no frame.
  - SHIFT: data bits on the wire.
  - PAR: parity bit; exists only with the optional feature.
- Reset (asynchronous, immediate, also mid-frame):
  - state = IDLE; shift register, bit counter, ser_out, ser_valid and ser_last = 0.
  - Any in-flight frame is dropped silently; no partial ser_last is produced.
- in_ready is combinational:
  - 1 in IDLE.
  - 1 in the final-bit cycle: SHIFT with counter = WIDTH-1 and no parity, or PAR.
  - 0 otherwise.
  - It reads 1 while rst is high, but no acceptance occurs during reset.
- Acceptance: rising edge with in_valid & in_ready.
  - Shift register loads data_in; counter <= 0; state <= SHIFT.
  - ser_out <= first bit; ser_valid <= 1.
  - Latency: first bit is visible the cycle after the accept edge.
- SHIFT:
  - Each edge advances one bit and the counter increments.
  - ser_valid stays 1 for exactly WIDTH consecutive cycles per frame.
  - Bit order follows MSB_FIRST.
  - ser_last = 1 only with the final bit (counter = WIDTH-1), without parity.
- End of frame (last-bit edge):
  - If a new word is accepted on that edge: reload and go to SHIFT; ser_valid stays 1 with no gap.
  - Otherwise: state <= IDLE; ser_valid, ser_last, ser_out <= 0.
- in_valid while in_ready = 0 is ignored; the word is not latched and the producer must hold it.
- data_in changes after acceptance do not affect the frame in flight.
- Counter width is clog2(WIDTH); no wrap beyond WIDTH-1 is reachable.
- busy = 1 from the accept edge through the last-bit cycle.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra PAR cycle outputs even parity (XOR of the word captured at acceptance).
  - ser_valid stays 1 and ser_last is asserted on the parity bit, not the last data bit.
  - Frame length is WIDTH+1 cycles.
  - Back-to-back acceptance happens on the PAR cycle.
- Undefined: PAR state and parity logic are absent; frame length is WIDTH cycles.

Decomposition:
- Shared package piso_pkg:
  - State typedef {IDLE, SHIFT, PAR}.
  - Localparam helper for counter width, clog2(WIDTH).
  - PARITY_EVEN constant.
- No sub-module needed; the shift register, counter and FSM stay in one module. A separate bit-counter sub-module is not warranted.

Test Plan:
- Reset then idle, WIDTH=4: in_ready=1, ser_valid=0, ser_out=0, busy=0.
- MSB_FIRST=1, accept 4'b1011 -> ser_out 1,0,1,1 on the next 4 cycles; ser_valid=1 all 4; ser_last only on the 4th; then ser_valid=0.
- Back-to-back: 4'hA, then 4'h5 presented on the last-bit cycle -> 8 contiguous valid cycles 1,0,1,0,0,1,0,1; ser_last on cycles 4 and 8.
- MSB_FIRST=0, 4'b0001 -> 1,0,0,0; in_valid with 4'hF asserted mid-frame while in_ready=0 -> ignored, no extra frame.
- rst pulsed during the 2nd bit of 4'hC -> ser_valid=0 immediately, state IDLE, no ser_last; the next accepted 4'h3 transmits cleanly.
- PISO_PARITY_EN, 4'b0111 -> 0,1,1,1 then parity 1 with ser_last on the 5th cycle; 4'b0110 -> parity 0.
